bip_exec_ctrl: RTL and testbench
================================

Name: bip_exec_ctrl

Overview:
Run/debug sequencer for the BIP1 core. On a start command it clears the core, lets it execute until it fetches the HALT opcode (or a cycle-budget timeout), and snapshots PC, ACC and the executed-instruction count. It then streams a 7-byte report through the UART transmitter using a start/done handshake. It sits between the UART command path and the CPU's control unit enable/clear inputs.

Parameters:
NB_OPCODE, 5, opcode width of the fetched instruction
NB_ADRR, 11, program counter width (must be <= 16)
NB_DATA, 16, accumulator width (must be 16)
NB_CYCLES, 16, executed-instruction counter width (must be <= 16)
NB_BYTE, 8, UART byte width
HALT_OPCODE, 5'b00000, opcode that terminates execution

Ports:
i_clk  in  1  system clock, all logic on its rising edge
i_rst  in  1  asynchronous, active-low reset
i_start  in  1  one-cycle run command from the UART receive path
i_opcode  in  NB_OPCODE  opcode of the instruction currently presented to the control unit
i_pc  in  NB_ADRR  current program counter
i_acc  in  NB_DATA  current accumulator
i_tx_done  in  1  one-cycle pulse: UART finished the current byte
o_cpu_en  out  1  CPU execute enable (PC/ACC/RAM update only when high)
o_cpu_clr  out  1  synchronous clear of PC and ACC
o_tx_start  out  1  one-cycle pulse: send o_tx_data
o_tx_data  out  NB_BYTE  byte to transmit, stable from o_tx_start until i_tx_done
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse after last byte acknowledged

Behaviour:
- Reset (i_rst=0, any time, async): state IDLE; counter, snapshots, byte index cleared; all outputs 0.
- States: IDLE, CLEAR, RUN, LOAD, WAIT_TX, DONE.
- IDLE: i_start=1 -> CLEAR. Counter cleared on this transition.
- CLEAR: exactly one cycle, o_cpu_clr=1, o_cpu_en=0 -> RUN.
- RUN: o_cpu_en is combinational: 1 iff state==RUN and i_opcode!=HALT_OPCODE and count!=all-ones. Counter +1 on every cycle o_cpu_en=1 (never wraps).
  - i_opcode==HALT_OPCODE: HALT is not executed; snapshot i_pc, i_acc, count; timeout flag=0; -> LOAD.
  - else count==all-ones: snapshot likewise; timeout flag=1; -> LOAD. HALT wins if both hold.
- Report bytes, in order: status {7'b0, timeout}, PC[15:8], PC[7:0], ACC[15:8], ACC[7:0], CNT[15:8], CNT[7:0]. PC and CNT are zero-extended to 16 bits.
- LOAD: drive o_tx_data=byte[idx], pulse o_tx_start for one cycle -> WAIT_TX.
- WAIT_TX: o_tx_data held. On i_tx_done: if idx==6 -> DONE, else idx+1 -> LOAD. No timeout on i_tx_done.
- DONE: o_done=1 for one cycle -> IDLE. Snapshots are kept until the next start.
- i_start outside IDLE is ignored, with no queuing. i_tx_done outside WAIT_TX is ignored.
- o_tx_start and i_tx_done pulses never overlap. The minimum gap between o_tx_start pulses is 2 cycles.
- Latency: i_start sampled at edge N gives CLEAR in cycle N+1 and the first enabled execution in N+2. HALT seen in cycle M gives o_tx_start in cycle M+2.

Test Plan:
1. Hold i_rst=0 and toggle i_start/i_tx_done -> all outputs stay 0. Release -> o_busy=0 and no pulses.
2. Start; i_opcode sequence 00001, 00010, 00011, then 00000; i_pc=3 and i_acc=0x0005 at halt; tx_done answered after 3 cycles -> o_cpu_clr for 1 cycle, o_cpu_en high exactly 3 cycles, bytes 00 00 03 00 05 00 03, one o_done pulse, then IDLE.
3. Start with i_opcode=00000 from the first RUN cycle, i_pc=0, i_acc=0xBEEF -> o_cpu_en never high; bytes 00 00 00 BE EF 00 00.
4. NB_CYCLES=4 with i_opcode held at 00001, i_pc=0x7FF, i_acc=0x1234 -> o_cpu_en high 15 cycles; bytes 01 07 FF 12 34 00 0F.
5. i_start pulsed during RUN and WAIT_TX; i_tx_done delayed 20 cycles; spurious i_tx_done during LOAD/RUN -> no restart, exactly 7 o_tx_start pulses, o_tx_data stable throughout each wait.
6. Assert i_rst=0 during the 4th WAIT_TX -> outputs go 0 immediately. After release, a new start with a halt after 1 instruction gives a correct full 7-byte report.

Source files
------------

// File: rtl/bip_exec_ctrl.sv
// Run/debug sequencer for the BIP1 core: clears and runs the CPU until HALT or a
// cycle-budget timeout, then streams a 7-byte status/PC/ACC/count report over the UART.
module bip_exec_ctrl #(
    parameter int                   NB_OPCODE   = 5,
    parameter int                   NB_ADRR     = 11,
    parameter int                   NB_DATA     = 16,
    parameter int                   NB_CYCLES   = 16,
    parameter int                   NB_BYTE     = 8,
    parameter logic [NB_OPCODE-1:0] HALT_OPCODE = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [NB_OPCODE-1:0] i_opcode,
    input  logic [NB_ADRR-1:0]   i_pc,
    input  logic [NB_DATA-1:0]   i_acc,
    input  logic                 i_tx_done,
    output logic                 o_cpu_en,
    output logic                 o_cpu_clr,
    output logic                 o_tx_start,
    output logic [NB_BYTE-1:0]   o_tx_data,
    output logic                 o_busy,
    output logic                 o_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_LOAD,
        ST_WAIT_TX,
        ST_DONE
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'd6;

    state_t               state;
    logic [NB_CYCLES-1:0] cnt;
    logic [NB_ADRR-1:0]   snap_pc;
    logic [NB_DATA-1:0]   snap_acc;
    logic [NB_CYCLES-1:0] snap_cnt;
    logic                 snap_tmo;
    logic [2:0]           idx;

    logic                 is_halt;
    logic                 cnt_max;
    logic [15:0]          pc16;
    logic [15:0]          acc16;
    logic [15:0]          cnt16;
    logic [7:0]           byte_sel;

    assign is_halt = (i_opcode == HALT_OPCODE);
    assign cnt_max = &cnt;

    // HALT itself is never executed, and a saturated counter freezes the core.
    assign o_cpu_en = (state == ST_RUN) && !is_halt && !cnt_max;

    assign pc16  = 16'(snap_pc);
    assign acc16 = 16'(snap_acc);
    assign cnt16 = 16'(snap_cnt);

    always_comb begin
        byte_sel = 8'h00;
        case (idx)
            3'd0:    byte_sel = {7'b0, snap_tmo};
            3'd1:    byte_sel = pc16[15:8];
            3'd2:    byte_sel = pc16[7:0];
            3'd3:    byte_sel = acc16[15:8];
            3'd4:    byte_sel = acc16[7:0];
            3'd5:    byte_sel = cnt16[15:8];
            3'd6:    byte_sel = cnt16[7:0];
            default: byte_sel = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            snap_pc    <= '0;
            snap_acc   <= '0;
            snap_cnt   <= '0;
            snap_tmo   <= 1'b0;
            idx        <= '0;
            o_cpu_clr  <= 1'b0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_cpu_clr  <= 1'b0;
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state     <= ST_CLEAR;
                        cnt       <= '0;
                        o_cpu_clr <= 1'b1;
                        o_busy    <= 1'b1;
                    end
                end
                ST_CLEAR: state <= ST_RUN;
                ST_RUN: begin
                    if (is_halt || cnt_max) begin
                        snap_pc  <= i_pc;
                        snap_acc <= i_acc;
                        snap_cnt <= cnt;
                        snap_tmo <= !is_halt;
                        idx      <= '0;
                        state    <= ST_LOAD;
                    end else begin
                        cnt <= cnt + NB_CYCLES'(1);
                    end
                end
                ST_LOAD: begin
                    o_tx_start <= 1'b1;
                    o_tx_data  <= NB_BYTE'(byte_sel);
                    state      <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    // A done coinciding with our own start pulse cannot belong to this byte.
                    if (i_tx_done && !o_tx_start) begin
                        if (idx == LAST_IDX) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bip_exec_ctrl.sv
// Directed bench for bip_exec_ctrl: default instance u0 and a 4-bit-counter instance u1
// for the cycle-budget timeout.
module tb_bip_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  start_v;
    logic [1:0]  txd_v;
    logic [4:0]  opcode;
    logic [10:0] pc;
    logic [15:0] acc;

    logic       en0, clr0, st0, busy0, done0;
    logic       en1, clr1, st1, busy1, done1;
    logic [7:0] data0, data1;

    int total = 0;
    int bad   = 0;
    int en_n[2], clr_n[2], st_n[2], done_n[2];

    always #5 clk = ~clk;

    bip_exec_ctrl u0 (
        .i_clk(clk), .i_rst(rst_n), .i_start(start_v[0]), .i_opcode(opcode),
        .i_pc(pc), .i_acc(acc), .i_tx_done(txd_v[0]),
        .o_cpu_en(en0), .o_cpu_clr(clr0), .o_tx_start(st0), .o_tx_data(data0),
        .o_busy(busy0), .o_done(done0)
    );

    bip_exec_ctrl #(.NB_CYCLES(4)) u1 (
        .i_clk(clk), .i_rst(rst_n), .i_start(start_v[1]), .i_opcode(opcode),
        .i_pc(pc), .i_acc(acc), .i_tx_done(txd_v[1]),
        .o_cpu_en(en1), .o_cpu_clr(clr1), .o_tx_start(st1), .o_tx_data(data1),
        .o_busy(busy1), .o_done(done1)
    );

    initial begin
        for (int i = 0; i < 2; i++) begin
            en_n[i] = 0; clr_n[i] = 0; st_n[i] = 0; done_n[i] = 0;
        end
    end

    // Pulse/enable counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (en0)   en_n[0]++;
        if (clr0)  clr_n[0]++;
        if (st0)   st_n[0]++;
        if (done0) done_n[0]++;
        if (en1)   en_n[1]++;
        if (clr1)  clr_n[1]++;
        if (st1)   st_n[1]++;
        if (done1) done_n[1]++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic f_start(input int s);
        return (s == 1) ? st1 : st0;
    endfunction

    function automatic logic [7:0] f_data(input int s);
        return (s == 1) ? data1 : data0;
    endfunction

    // Acknowledges nb bytes dly cycles after each start; spur adds stray start/done pulses.
    task automatic get_report(input int sel, input int dly, input int nb, input bit spur,
                              output logic [7:0] b [0:6], output int unstable, output int tmo);
        int w;
        logic [7:0] d;
        unstable = 0;
        tmo = 0;
        for (int k = 0; k < 7; k++) b[k] = 8'h00;
        for (int k = 0; k < nb; k++) begin
            w = 0;
            while (!f_start(sel) && w < 200) begin
                tick;
                w++;
            end
            if (w >= 200) begin
                tmo = 1;
                break;
            end
            txd_v[sel] = 1'b0;
            d = f_data(sel);
            b[k] = d;
            for (int j = 0; j < dly; j++) begin
                tick;
                if (f_data(sel) !== d) unstable++;
                start_v[sel] = spur && (j == 1);
            end
            start_v[sel] = 1'b0;
            txd_v[sel] = 1'b1;
            tick;
            txd_v[sel] = spur;
        end
        txd_v[sel] = 1'b0;
        start_v[sel] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            start_v = {2{i[0]}};
            txd_v = {2{i[1]}};
            tick;
            total++;
            if ({en0, clr0, st0, busy0, done0, data0, en1, clr1, st1, busy1, done1, data1} !== '0) begin
                bad++;
                $display("FAIL reset_hold cyc%0d got u0=%b%b%b%b%b/%02h u1=%b%b%b%b%b/%02h want all 0",
                         i, en0, clr0, st0, busy0, done0, data0, en1, clr1, st1, busy1, done1, data1);
            end
        end
        start_v = 2'b00;
        txd_v = 2'b00;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            total++;
            if ({clr0, st0, busy0, done0, clr1, st1, busy1, done1} !== 8'h00) begin
                bad++;
                $display("FAIL reset_release cyc%0d got %b want 00000000",
                         i, {clr0, st0, busy0, done0, clr1, st1, busy1, done1});
            end
        end
    endtask

    task automatic test_basic_run;
        logic [7:0] b [0:6];
        logic [7:0] want [0:6];
        int un, tmo, e0, c0, s0, d0;
        want = '{8'h00, 8'h00, 8'h03, 8'h00, 8'h05, 8'h00, 8'h03};
        e0 = en_n[0]; c0 = clr_n[0]; s0 = st_n[0]; d0 = done_n[0];
        opcode = 5'd1; pc = 11'd0; acc = 16'h0;
        start_v[0] = 1'b1;
        tick;
        start_v[0] = 1'b0;
        total++;
        if ({clr0, busy0} !== 2'b11) begin
            bad++;
            $display("FAIL basic_clear got clr/busy=%b%b want 11", clr0, busy0);
        end
        tick; opcode = 5'd1;
        tick; opcode = 5'd2;
        tick; opcode = 5'd3;
        tick; opcode = 5'd0; pc = 11'd3; acc = 16'h0005;
        tick;
        total++;
        if (st0 !== 1'b0) begin
            bad++;
            $display("FAIL basic_latency_load got tx_start=%b want 0", st0);
        end
        tick;
        total++;
        if (st0 !== 1'b1) begin
            bad++;
            $display("FAIL basic_latency_start got tx_start=%b want 1", st0);
        end
        get_report(0, 3, 7, 1'b0, b, un, tmo);
        tick; tick; tick;
        for (int k = 0; k < 7; k++) begin
            total++;
            if (b[k] !== want[k]) begin
                bad++;
                $display("FAIL basic_byte%0d got %02h want %02h", k, b[k], want[k]);
            end
        end
        total++;
        if ((en_n[0] - e0) != 3 || (clr_n[0] - c0) != 1) begin
            bad++;
            $display("FAIL basic_en_clr got en=%0d clr=%0d want en=3 clr=1", en_n[0] - e0, clr_n[0] - c0);
        end
        total++;
        if ((st_n[0] - s0) != 7 || (done_n[0] - d0) != 1 || tmo != 0 || un != 0 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL basic_handshake got starts=%0d done=%0d tmo=%0d unstable=%0d busy=%b want 7 1 0 0 0",
                     st_n[0] - s0, done_n[0] - d0, tmo, un, busy0);
        end
    endtask

    task automatic test_halt_first;
        logic [7:0] b [0:6];
        logic [7:0] want [0:6];
        int un, tmo, e0, d0;
        want = '{8'h00, 8'h00, 8'h00, 8'hBE, 8'hEF, 8'h00, 8'h00};
        e0 = en_n[0]; d0 = done_n[0];
        opcode = 5'd0; pc = 11'd0; acc = 16'hBEEF;
        start_v[0] = 1'b1;
        tick;
        start_v[0] = 1'b0;
        get_report(0, 2, 7, 1'b0, b, un, tmo);
        tick; tick;
        for (int k = 0; k < 7; k++) begin
            total++;
            if (b[k] !== want[k]) begin
                bad++;
                $display("FAIL halt_first_byte%0d got %02h want %02h", k, b[k], want[k]);
            end
        end
        total++;
        if ((en_n[0] - e0) != 0 || (done_n[0] - d0) != 1 || tmo != 0) begin
            bad++;
            $display("FAIL halt_first_ctrl got en=%0d done=%0d tmo=%0d want 0 1 0", en_n[0] - e0, done_n[0] - d0, tmo);
        end
    endtask

    task automatic test_timeout;
        logic [7:0] b [0:6];
        logic [7:0] want [0:6];
        int un, tmo, e1, d1;
        want = '{8'h01, 8'h07, 8'hFF, 8'h12, 8'h34, 8'h00, 8'h0F};
        e1 = en_n[1]; d1 = done_n[1];
        opcode = 5'd1; pc = 11'h7FF; acc = 16'h1234;
        start_v[1] = 1'b1;
        tick;
        start_v[1] = 1'b0;
        get_report(1, 2, 7, 1'b0, b, un, tmo);
        tick; tick;
        for (int k = 0; k < 7; k++) begin
            total++;
            if (b[k] !== want[k]) begin
                bad++;
                $display("FAIL timeout_byte%0d got %02h want %02h", k, b[k], want[k]);
            end
        end
        total++;
        if ((en_n[1] - e1) != 15 || (done_n[1] - d1) != 1 || tmo != 0 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL timeout_ctrl got en=%0d done=%0d tmo=%0d busy=%b want 15 1 0 0",
                     en_n[1] - e1, done_n[1] - d1, tmo, busy1);
        end
    endtask

    task automatic test_ignore;
        logic [7:0] b [0:6];
        logic [7:0] want [0:6];
        int un, tmo, e0, c0, s0, d0;
        want = '{8'h00, 8'h00, 8'h10, 8'h00, 8'h42, 8'h00, 8'h03};
        e0 = en_n[0]; c0 = clr_n[0]; s0 = st_n[0]; d0 = done_n[0];
        opcode = 5'd1; pc = 11'h010; acc = 16'h0042;
        start_v[0] = 1'b1;
        tick;
        start_v[0] = 1'b0;
        tick;
        tick; start_v[0] = 1'b1; txd_v[0] = 1'b1;
        tick; start_v[0] = 1'b0; txd_v[0] = 1'b0;
        tick; opcode = 5'd0;
        get_report(0, 20, 7, 1'b1, b, un, tmo);
        for (int i = 0; i < 5; i++) tick;
        for (int k = 0; k < 7; k++) begin
            total++;
            if (b[k] !== want[k]) begin
                bad++;
                $display("FAIL ignore_byte%0d got %02h want %02h", k, b[k], want[k]);
            end
        end
        total++;
        if ((st_n[0] - s0) != 7 || un != 0 || tmo != 0) begin
            bad++;
            $display("FAIL ignore_tx got starts=%0d unstable=%0d tmo=%0d want 7 0 0", st_n[0] - s0, un, tmo);
        end
        total++;
        if ((en_n[0] - e0) != 3 || (clr_n[0] - c0) != 1 || (done_n[0] - d0) != 1 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL ignore_restart got en=%0d clr=%0d done=%0d busy=%b want 3 1 1 0",
                     en_n[0] - e0, clr_n[0] - c0, done_n[0] - d0, busy0);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b [0:6];
        logic [7:0] want [0:6];
        int un, tmo, w, e0, d0;
        want = '{8'h00, 8'h01, 8'h23, 8'hA5, 8'hA5, 8'h00, 8'h01};
        opcode = 5'd1; pc = 11'h055; acc = 16'h0077;
        start_v[0] = 1'b1;
        tick;
        start_v[0] = 1'b0;
        tick;
        tick; opcode = 5'd0;
        get_report(0, 3, 3, 1'b0, b, un, tmo);
        w = 0;
        while (!st0 && w < 200) begin
            tick;
            w++;
        end
        total++;
        if (w >= 200) begin
            bad++;
            $display("FAIL reset_mid_wait got no 4th tx_start within %0d cycles want tx_start", w);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({en0, clr0, st0, busy0, done0, data0} !== 13'h0) begin
            bad++;
            $display("FAIL reset_mid_async got %b%b%b%b%b/%02h want all 0", en0, clr0, st0, busy0, done0, data0);
        end
        tick; tick;
        rst_n = 1'b1;
        tick;
        e0 = en_n[0]; d0 = done_n[0];
        opcode = 5'd1; pc = 11'h123; acc = 16'hA5A5;
        start_v[0] = 1'b1;
        tick;
        start_v[0] = 1'b0;
        tick; opcode = 5'd1;
        tick; opcode = 5'd0;
        get_report(0, 1, 7, 1'b0, b, un, tmo);
        tick; tick;
        for (int k = 0; k < 7; k++) begin
            total++;
            if (b[k] !== want[k]) begin
                bad++;
                $display("FAIL reset_mid_byte%0d got %02h want %02h", k, b[k], want[k]);
            end
        end
        total++;
        if ((en_n[0] - e0) != 1 || (done_n[0] - d0) != 1 || tmo != 0 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_ctrl got en=%0d done=%0d tmo=%0d busy=%b want 1 1 0 0",
                     en_n[0] - e0, done_n[0] - d0, tmo, busy0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start_v = 2'b00;
        txd_v = 2'b00;
        opcode = 5'd0;
        pc = 11'd0;
        acc = 16'h0;
        test_reset;
        test_basic_run;
        test_halt_first;
        test_timeout;
        test_ignore;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
